// File: rtl/mem_store_buffer_if.sv
// Data-memory bus between the store buffer (master) and the single-port data memory (slave).
interface mem_store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_be;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: posts stores into a FIFO, drains them to data memory, arbitrates loads.
// Optional store-to-load forwarding of full-word hits is enabled by defining STORE_FWD_EN.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemWriteM,
    input  logic                MemReadM,
    input  logic [ADDR_W-1:0]   AddrM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [DATA_W/8-1:0] ByteEnM,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic                stall_mem_2_store,
    output logic                sb_empty,
    mem_store_buffer_if.master  dmem
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    typedef struct packed {
        logic [WA_W-1:0]   waddr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    state_e             state_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [ADDR_W-1:0]  ld_addr_q;

    logic               full, hit, push, pop, drain;
    logic [DEPTH-1:0]   match;
    logic [PTR_W-1:0]   slot;
    logic               fwd_ok;
    logic [DATA_W-1:0]  fwd_data;
    entry_t             head;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign sb_empty = (count_q == '0);
    assign head     = fifo_q[rd_ptr_q];

    // match[i] flags the i-th oldest valid entry holding the load's word address.
    always_comb begin
        match = '0;
        slot  = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot     = rd_ptr_q + PTR_W'(i);
            match[i] = ((PTR_W+1)'(i) < count_q) &&
                       (fifo_q[slot].waddr == AddrM[ADDR_W-1:2]);
        end
    end

    assign hit = |match;

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] fwd_slot;

    // Oldest-to-youngest scan so the last match wins: the youngest store owns the data.
    always_comb begin
        fwd_slot = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) fwd_slot = rd_ptr_q + PTR_W'(i);
        end
    end

    assign fwd_ok   = hit && (&fifo_q[fwd_slot].be);
    assign fwd_data = fifo_q[fwd_slot].data;
`else
    assign fwd_ok   = 1'b0;
    assign fwd_data = '0;
`endif

    // NOTE: every output gets a default up front so no path through the case infers a latch.
    always_comb begin
        dmem.dmem_req     = 1'b0;
        dmem.dmem_we      = 1'b0;
        dmem.dmem_addr    = '0;
        dmem.dmem_wdata   = '0;
        dmem.dmem_be      = '0;
        stall_mem_2_store = 1'b0;
        push              = 1'b0;
        pop               = 1'b0;
        drain             = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemReadM) begin
                    stall_mem_2_store = 1'b1;
                    if (!hit) begin
                        dmem.dmem_req  = 1'b1;
                        dmem.dmem_addr = AddrM;
                    end else if (!fwd_ok) begin
                        drain = 1'b1;
                    end
                end else if (!sb_empty) begin
                    drain = 1'b1;
                end
                if (MemWriteM) begin
                    if (full) stall_mem_2_store = 1'b1;
                    else      push              = 1'b1;
                end
            end
            LOAD: begin
                dmem.dmem_req     = 1'b1;
                dmem.dmem_addr    = ld_addr_q;
                stall_mem_2_store = 1'b1;
            end
            DONE:    ;
            default: ;
        endcase
        if (drain) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = 1'b1;
            dmem.dmem_addr  = {head.waddr, 2'b00};
            dmem.dmem_wdata = head.data;
            dmem.dmem_be    = head.be;
            pop             = dmem.dmem_ready;
        end
    end

    assign ReadDataM = (state_q == DONE) ? rdata_q : '0;

    // NOTE: the entry storage carries no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{waddr: AddrM[ADDR_W-1:2], data: WriteDataM, be: ByteEnM};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rdata_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            unique case (state_q)
                IDLE: begin
                    if (MemReadM && !hit) begin
                        ld_addr_q <= AddrM;
                        if (dmem.dmem_ready) begin
                            rdata_q <= dmem.dmem_rdata;
                            state_q <= DONE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end else if (MemReadM && fwd_ok) begin
                        rdata_q <= fwd_data;
                        state_q <= DONE;
                    end
                end
                LOAD: begin
                    if (dmem.dmem_ready) begin
                        rdata_q <= dmem.dmem_rdata;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer: small data-memory model plus per-scenario test tasks.
module tb_mem_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM, MemReadM;
    logic [31:0] AddrM, WriteDataM;
    logic [3:0]  ByteEnM;
    logic [31:0] ReadDataM;
    logic        stall_mem_2_store, sb_empty;

    int errors = 0;
    int checks = 0;

    mem_store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .MemWriteM         (MemWriteM),
        .MemReadM          (MemReadM),
        .AddrM             (AddrM),
        .WriteDataM        (WriteDataM),
        .ByteEnM           (ByteEnM),
        .ReadDataM         (ReadDataM),
        .stall_mem_2_store (stall_mem_2_store),
        .sb_empty          (sb_empty),
        .dmem              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        log_q[$];
    logic [31:0] mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    // Memory model: completes a transfer on every req & ready edge and logs it.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.dmem_be[b]) mem[bus.dmem_addr[9:2]][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
        end
        if (bus.dmem_req && bus.dmem_ready)
            log_q.push_back('{we: bus.dmem_we, addr: bus.dmem_addr, data: bus.dmem_wdata});
    end

    always_comb bus.dmem_rdata = mem[bus.dmem_addr[9:2]];

    always @(posedge clk)
        if (!rst) assert (!(MemWriteM && MemReadM)) else $error("illegal: MemWriteM and MemReadM together");

    function automatic txn_t get_txn(int idx);
        txn_t t = '{we: 1'b0, addr: 32'hFFFF_FFFF, data: 32'h0};
        if (idx < log_q.size()) t = log_q[idx];
        return t;
    endfunction

    function automatic int count_reads(int base);
        int n = 0;
        for (int i = base; i < log_q.size(); i++) if (!log_q[i].we) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] addr, input logic [31:0] val);
        pre_en  = 1'b1;
        pre_idx = addr[9:2];
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic store_cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                               output logic stall);
        MemWriteM  = 1'b1;
        AddrM      = a;
        WriteDataM = d;
        ByteEnM    = be;
        @(negedge clk);
        stall = stall_mem_2_store;
        tick();
        MemWriteM = 1'b0;
    endtask

    task automatic wait_empty(output logic ok);
        ok = 1'b0;
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_empty) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        bus.dmem_ready = 1'b0;
    endtask

    // Holds the load until the stall drops; ready rises once ready_delay cycles have elapsed.
    task automatic do_load(input logic [31:0] a, input int ready_delay,
                           output int nstall, output logic [31:0] data, output logic done,
                           output logic f_req, output logic f_we, output logic [31:0] f_addr);
        nstall = 0; data = '0; done = 1'b0;
        f_req = 1'b0; f_we = 1'b0; f_addr = '0;
        MemReadM = 1'b1;
        AddrM    = a;
        for (int k = 0; k < 50; k++) begin
            bus.dmem_ready = (k >= ready_delay);
            @(negedge clk);
            if (k == 0) begin
                f_req = bus.dmem_req; f_we = bus.dmem_we; f_addr = bus.dmem_addr;
            end
            if (stall_mem_2_store) begin
                nstall++;
            end else begin
                data = ReadDataM;
                done = 1'b1;
                break;
            end
            tick();
        end
        tick();
        MemReadM       = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b1;
        AddrM = 32'h40; WriteDataM = 32'h5555_AAAA; ByteEnM = 4'hF;
        bus.dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty: got %b want 1", sb_empty); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.dmem_req); end
        checks++; if (stall_mem_2_store !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_mem_2_store); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
        tick();
        rst = 1'b0; MemWriteM = 1'b0;
        @(negedge clk);
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_discard: sb_empty got %b want 1", sb_empty); end
        tick();
    endtask

    task automatic test_posted_stores();
        int   base = log_q.size();
        logic st, ok;
        for (int i = 0; i < 3; i++) begin
            store_cycle(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, st);
            checks++; if (st !== 1'b0) begin errors++; $display("FAIL posted_stall[%0d]: got %b want 0", i, st); end
        end
        @(negedge clk);
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL posted_not_empty: got %b want 0", sb_empty); end
        checks++; if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr} !== {2'b11, 32'h100})
            begin errors++; $display("FAIL posted_head_req: got req=%b we=%b addr=%h want 1 1 00000100",
                                     bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
        tick();
        wait_empty(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL posted_drain_timeout: got %b want 1", ok); end
        checks++; if (log_q.size() - base != 3) begin errors++; $display("FAIL posted_count: got %0d want 3", log_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            txn_t t = get_txn(base + i);
            checks++;
            if ({t.we, t.addr, t.data} !== {1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i)}) begin
                errors++; $display("FAIL posted_order[%0d]: got we=%b addr=%h data=%h want 1 %h %h", i, t.we, t.addr,
                                   t.data, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_full();
        int   base = log_q.size();
        logic st, ok;
        for (int i = 0; i < 4; i++) begin
            store_cycle(32'h400 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF, st);
            checks++; if (st !== 1'b0) begin errors++; $display("FAIL full_fill_stall[%0d]: got %b want 0", i, st); end
        end
        MemWriteM = 1'b1; AddrM = 32'h410; WriteDataM = 32'hB000_0004; ByteEnM = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (stall_mem_2_store !== 1'b1) begin errors++; $display("FAIL full_stall[%0d]: got 0 want 1", c); end
            tick();
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        checks++; if (stall_mem_2_store !== 1'b1) begin errors++; $display("FAIL full_stall_on_pop: got 0 want 1"); end
        tick();
        @(negedge clk);
        checks++; if (stall_mem_2_store !== 1'b0) begin errors++; $display("FAIL full_release: got 1 want 0"); end
        tick();
        MemWriteM = 1'b0;
        wait_empty(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_drain_timeout: got %b want 1", ok); end
        checks++; if (log_q.size() - base != 5) begin errors++; $display("FAIL full_count: got %0d want 5", log_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            txn_t t = get_txn(base + i);
            checks++;
            if ({t.addr, t.data} !== {32'h400 + 32'(4*i), 32'hB000_0000 + 32'(i)}) begin
                errors++; $display("FAIL full_order[%0d]: got addr=%h data=%h want %h %h", i, t.addr, t.data,
                                   32'h400 + 32'(4*i), 32'hB000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_clean_load();
        int          n;
        logic [31:0] d, fa;
        logic        done, fr, fw;
        preset(32'h200, 32'hDEAD_BEEF);
        do_load(32'h200, 0, n, d, done, fr, fw, fa);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_timeout: got %b want 1", done); end
        checks++; if (n != 1) begin errors++; $display("FAIL clean_stall_cycles: got %0d want 1", n); end
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL clean_rdata: got %h want deadbeef", d); end
        checks++; if ({fr, fw, fa} !== {2'b10, 32'h200})
            begin errors++; $display("FAIL clean_issue: got req=%b we=%b addr=%h want 1 0 00000200", fr, fw, fa); end
        @(negedge clk);
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL clean_rdata_after_done: got %h want 0", ReadDataM); end
        tick();
    endtask

    task automatic test_load_hit();
        int          base, n;
        logic [31:0] d, fa;
        logic        done, fr, fw, st, ok;
        txn_t        t0, t1;
        preset(32'h300, 32'h0000_0000);
        store_cycle(32'h300, 32'h1122_3344, 4'hF, st);
        base = log_q.size();
        do_load(32'h300, 2, n, d, done, fr, fw, fa);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hit_timeout: got %b want 1", done); end
        checks++; if (d !== 32'h1122_3344) begin errors++; $display("FAIL hit_rdata: got %h want 11223344", d); end
`ifdef STORE_FWD_EN
        checks++; if (n != 1) begin errors++; $display("FAIL hit_fwd_stall: got %0d want 1", n); end
        checks++; if (fr !== 1'b0) begin errors++; $display("FAIL hit_fwd_no_req: got %b want 0", fr); end
        checks++; if (count_reads(base) != 0) begin errors++; $display("FAIL hit_fwd_reads: got %0d want 0", count_reads(base)); end
        wait_empty(ok);
        t0 = get_txn(base);
        checks++; if ({ok, t0.we, t0.addr, t0.data} !== {2'b11, 32'h300, 32'h1122_3344})
            begin errors++; $display("FAIL hit_fwd_drain: got ok=%b we=%b addr=%h data=%h want 1 1 300 11223344",
                                     ok, t0.we, t0.addr, t0.data); end
`else
        checks++; if (n != 4) begin errors++; $display("FAIL hit_stall_cycles: got %0d want 4", n); end
        checks++; if ({fr, fw, fa} !== {2'b11, 32'h300})
            begin errors++; $display("FAIL hit_first_drain: got req=%b we=%b addr=%h want 1 1 00000300", fr, fw, fa); end
        t0 = get_txn(base);
        t1 = get_txn(base + 1);
        checks++; if ({t0.we, t0.addr, t1.we, t1.addr} !== {1'b1, 32'h300, 1'b0, 32'h300})
            begin errors++; $display("FAIL hit_order: got %b/%h then %b/%h want write then read of 300",
                                     t0.we, t0.addr, t1.we, t1.addr); end
`endif
        checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL hit_empty_after: got %b want 1", sb_empty); end
    endtask

    task automatic test_partial_hit();
        int          base, n;
        logic [31:0] d, fa;
        logic        done, fr, fw, st;
        txn_t        t0, t1;
        preset(32'h304, 32'hAABB_CCDD);
        store_cycle(32'h304, 32'h1122_3344, 4'b0011, st);
        base = log_q.size();
        do_load(32'h304, 2, n, d, done, fr, fw, fa);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL partial_timeout: got %b want 1", done); end
        checks++; if (n != 4) begin errors++; $display("FAIL partial_stall_cycles: got %0d want 4", n); end
        checks++; if (d !== 32'hAABB_3344) begin errors++; $display("FAIL partial_rdata: got %h want aabb3344", d); end
        checks++; if ({fr, fw} !== 2'b11) begin errors++; $display("FAIL partial_drain_first: got req=%b we=%b want 1 1", fr, fw); end
        t0 = get_txn(base);
        t1 = get_txn(base + 1);
        checks++; if ({t0.we, t1.we, t1.addr} !== {1'b1, 1'b0, 32'h304})
            begin errors++; $display("FAIL partial_order: got we=%b then we=%b addr=%h want 1 0 304", t0.we, t1.we, t1.addr); end
    endtask

    task automatic test_back_to_back();
        int          base, n;
        logic [31:0] d, fa;
        logic        done, fr, fw, st, ok;
        txn_t        t0, t1, t2;
        preset(32'h600, 32'hCAFE_F00D);
        base = log_q.size();
        store_cycle(32'h500, 32'h5050_5050, 4'hF, st);
        store_cycle(32'h504, 32'h5454_5454, 4'hF, st);
        do_load(32'h600, 0, n, d, done, fr, fw, fa);
        checks++; if ({fr, fw, fa} !== {2'b10, 32'h600})
            begin errors++; $display("FAIL b2b_load_priority: got req=%b we=%b addr=%h want 1 0 00000600", fr, fw, fa); end
        checks++; if (n != 1) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 1", n); end
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata: got %h want cafef00d", d); end
        wait_empty(ok);
        t0 = get_txn(base); t1 = get_txn(base + 1); t2 = get_txn(base + 2);
        checks++; if ({ok, t0.we, t1.addr, t2.addr} !== {2'b10, 32'h500, 32'h504})
            begin errors++; $display("FAIL b2b_drain_after: got ok=%b we0=%b a1=%h a2=%h want 1 0 500 504",
                                     ok, t0.we, t1.addr, t2.addr); end
    endtask

    initial begin
        test_reset();
        test_posted_stores();
        test_full();
        test_clean_load();
        test_load_hit();
        test_partial_hit();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
